mem_stage_lsu: RTL and testbench

Parametrised MEM pipeline stage with an integrated load/store unit. It sits between EX and WB. It replaces the fixed single-cycle data-SRAM read with a req/gnt/rvalid memory handshake, byte/halfword access, and misalignment detection. Its stall output and forwarding bus let ID interlock on loads that are still in flight. At most one memory transaction is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 57 +++++
 rtl/mem_stage_lsu_align.sv | 31 +++
 rtl/mem_stage_lsu.sv | 140 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared mem-op encoding and the byte-lane helpers used by EX decode, the LSU and its bench.
package mem_stage_lsu_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} lsu_state_t;

  function automatic logic op_is_load(logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_misaligned(logic [3:0] op, logic [1:0] lane);
    logic half, word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (half && lane[0]) || (word && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] be_gen(logic [3:0] op, logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_SB:   be = 4'b0001 << lane;
      OP_SH:   be = 4'b0011 << lane;
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extract(logic [3:0] op, logic [1:0] lane,
                                               logic [31:0] rdata);
    logic [31:0] sh, res;
    sh = rdata >> {lane, 3'b000};
    case (op)
      OP_LB:   res = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  res = {24'h0, sh[7:0]};
      OP_LH:   res = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  res = {16'h0, sh[15:0]};
      OP_LW:   res = rdata;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic for the instruction held in the MEM stage register.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  always_comb begin
    is_load    = op_is_load(op);
    is_store   = op_is_store(op);
    misaligned = op_misaligned(op, lane);
    be         = be_gen(op, lane);
    load_data  = load_extract(op, lane, rdata);
    case (op)
      OP_SB:   store_data = {4{wdata[7:0]}};
      OP_SH:   store_data = {2{wdata[15:0]}};
      OP_SW:   store_data = wdata;
      default: store_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with a one-outstanding req/gnt/rvalid load/store unit, WB register and ID bypass.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_rf_we,
  input  logic [REG_AW-1:0] ex_rf_waddr,
  input  logic [31:0]       ex_result,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic              fwd_we,
  output logic [REG_AW-1:0] fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              fwd_busy,
  output logic              misalign_exc,
  output logic [PC_W-1:0]   exc_pc
);

  lsu_state_t        state;
  logic              s_valid, s_kill, s_rf_we;
  logic [PC_W-1:0]   s_pc;
  logic [3:0]        s_op;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata, s_result;
  logic [REG_AW-1:0] s_rf_waddr;

  logic        s_is_load, s_is_store, s_misaligned;
  logic [3:0]  s_be;
  logic [31:0] s_store_data, s_load_data, s_value;
  logic        completing, capture, ex_to_mem, in_req;

  mem_stage_lsu_align u_align (
    .op         (s_op),
    .lane       (s_addr[1:0]),
    .wdata      (s_wdata),
    .rdata      (dmem_rdata),
    .is_load    (s_is_load),
    .is_store   (s_is_store),
    .misaligned (s_misaligned),
    .be         (s_be),
    .store_data (s_store_data),
    .load_data  (s_load_data)
  );

  // S only sits in IDLE with a non-memory or misaligned op, which finish immediately.
  assign completing = s_valid && ((state == ST_IDLE) ||
                                  (state == ST_REQ && s_is_store && dmem_gnt) ||
                                  (state == ST_WAIT && dmem_rvalid));
  assign ex_ready   = !s_valid || completing;
  assign capture    = ex_valid && ex_ready && !flush;
  assign ex_to_mem  = (op_is_load(ex_mem_op) || op_is_store(ex_mem_op)) &&
                      !op_misaligned(ex_mem_op, ex_addr[1:0]);
  assign s_value    = s_is_load ? s_load_data : s_result;

  assign in_req     = (state == ST_REQ);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req && s_is_store;
  assign dmem_be    = in_req ? s_be : 4'h0;
  assign dmem_addr  = in_req ? {s_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = in_req ? s_store_data : 32'h0;

  assign fwd_we       = s_valid && s_rf_we && !s_kill && !s_misaligned && (!s_is_load || completing);
  assign fwd_waddr    = s_rf_waddr;
  assign fwd_wdata    = s_value;
  assign fwd_busy     = s_valid && s_is_load && !completing;
  assign misalign_exc = s_valid && s_misaligned && !flush;
  assign exc_pc       = misalign_exc ? s_pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      s_valid     <= 1'b0;
      s_kill      <= 1'b0;
      s_pc        <= '0;
      s_op        <= OP_NONE;
      s_addr      <= '0;
      s_wdata     <= 32'h0;
      s_rf_we     <= 1'b0;
      s_rf_waddr  <= '0;
      s_result    <= 32'h0;
      wb_valid    <= 1'b0;
      wb_pc       <= '0;
      wb_rf_we    <= 1'b0;
      wb_rf_waddr <= '0;
      wb_rf_wdata <= 32'h0;
    end else begin
      wb_valid <= completing && !s_kill && !flush && !s_misaligned;
      if (completing) begin
        wb_pc       <= s_pc;
        wb_rf_we    <= s_rf_we && !s_misaligned;
        wb_rf_waddr <= s_rf_waddr;
        wb_rf_wdata <= s_value;
      end
      if (capture) begin
        s_valid    <= 1'b1;
        s_kill     <= 1'b0;
        s_pc       <= ex_pc;
        s_op       <= ex_mem_op;
        s_addr     <= ex_addr;
        s_wdata    <= ex_wdata;
        s_rf_we    <= ex_rf_we;
        s_rf_waddr <= ex_rf_waddr;
        s_result   <= ex_result;
        state      <= ex_to_mem ? ST_REQ : ST_IDLE;
      end else if (completing) begin
        s_valid <= 1'b0;
        s_kill  <= 1'b0;
        state   <= ST_IDLE;
      end else begin
        if (state == ST_REQ && dmem_gnt) state <= ST_WAIT;
        // A bus transaction in flight cannot be withdrawn, so it is marked dead instead.
        if (flush && s_valid) s_kill <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized checks of mem_stage_lsu against a transaction-level reference model.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_ready, ex_rf_we;
  logic [31:0] ex_pc, ex_addr, ex_wdata, ex_result;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rf_waddr;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_rf_we, fwd_we, fwd_busy, misalign_exc;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata, exc_pc;
  logic [4:0]  wb_rf_waddr, fwd_waddr;

  int n_assert = 0, n_fail = 0;
  int req_cycles, rdy_seen, busy_low;
  logic [31:0] o_be, o_wd, o_addr, o_we, o_fwd, o_fwd_we;

  always #5 clk = ~clk;

  mem_stage_lsu #(.PC_W(32), .ADDR_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_busy(fwd_busy),
    .misalign_exc(misalign_exc), .exc_pc(exc_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size, lane arithmetic and extension from first principles.
  function automatic int ref_size(logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit ref_mis(logic [3:0] op, logic [31:0] a);
    int sz;
    sz = ref_size(op);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] a, logic [31:0] rd);
    logic [31:0] w, b, h;
    w = rd >> (8 * (a % 4));
    b = w % 256;
    h = w % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_be(logic [3:0] op, logic [31:0] a);
    case (op)
      OP_SB:   return 32'd1 << (a % 4);
      OP_SH:   return 32'd3 << (a % 4);
      OP_SW:   return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_sdata(logic [3:0] op, logic [31:0] wd);
    case (op)
      OP_SB:   return (wd % 256) * 32'h0101_0101;
      OP_SH:   return (wd % 65536) * 32'h0001_0001;
      OP_SW:   return wd;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] res, input logic we, input logic [4:0] wa,
                       input logic [31:0] pc);
    ex_mem_op = op; ex_addr = a; ex_wdata = wd; ex_result = res;
    ex_rf_we = we; ex_rf_waddr = wa; ex_pc = pc; ex_valid = 1'b1;
    #1;
    chk("issue_ready", 32'(ex_ready), 32'd1);
    tick();
    ex_valid = 1'b0;
    ex_mem_op = OP_NONE;
  endtask

  // Memory responder: gnt after gl idle REQ cycles, rvalid after rl idle WAIT cycles.
  task automatic serve(input bit is_ld, input int gl, input int rl, input logic [31:0] rd);
    req_cycles = 0; rdy_seen = 0; busy_low = 0;
    for (int i = 0; i < gl; i++) begin
      if (dmem_req) req_cycles++;
      if (ex_ready) rdy_seen++;
      tick();
    end
    dmem_gnt = 1'b1;
    #1;
    if (dmem_req) req_cycles++;
    o_be = 32'(dmem_be); o_wd = dmem_wdata; o_addr = dmem_addr; o_we = 32'(dmem_we);
    tick();
    dmem_gnt = 1'b0;
    if (is_ld) begin
      for (int i = 0; i < rl; i++) begin
        if (!fwd_busy) busy_low++;
        if (ex_ready) rdy_seen++;
        tick();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rd;
      #1;
      o_fwd = fwd_wdata; o_fwd_we = 32'(fwd_we);
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, wd, res, pc, rd, exp;
    logic        we;
    logic [4:0]  wa;
    int          gl, rl;

    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_pc = 0; ex_mem_op = OP_NONE; ex_addr = 0;
    ex_wdata = 0; ex_rf_we = 1'b0; ex_rf_waddr = 0; ex_result = 0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_wdata", wb_rf_wdata, 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_dmem_be", 32'(dmem_be), 0);
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_fwd_busy", 32'(fwd_busy), 0);
    chk("rst_misalign", 32'(misalign_exc), 0);

    // Back-to-back ALU ops
    ex_valid = 1'b1; ex_mem_op = OP_NONE; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3; ex_result = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("alu_ready", 32'(ex_ready), 1);
      chk("alu_req", 32'(dmem_req), 0);
      if (i >= 1) begin
        chk("alu_wb_valid", 32'(wb_valid), 1);
        chk("alu_wb_wdata", wb_rf_wdata, 32'h1234);
        chk("alu_wb_waddr", 32'(wb_rf_waddr), 3);
      end
    end
    ex_valid = 1'b0;
    tick();
    chk("alu_last_wb", 32'(wb_valid), 1);
    tick();
    chk("alu_drain_wb", 32'(wb_valid), 0);

    // LB / LBU at 0x103
    issue(OP_LB, 32'h103, 0, 32'hDEAD, 1'b1, 5'd9, 32'h80);
    chk("lb_busy", 32'(fwd_busy), 1);
    serve(1, 0, 1, 32'h80FF_0000);
    chk("lb_busy_held", busy_low, 0);
    chk("lb_fwd", o_fwd, 32'hFFFF_FF80);
    chk("lb_wb_valid", 32'(wb_valid), 1);
    chk("lb_wb_wdata", wb_rf_wdata, 32'hFFFF_FF80);
    chk("lb_after_busy", 32'(fwd_busy), 0);
    issue(OP_LBU, 32'h103, 0, 32'hDEAD, 1'b1, 5'd9, 32'h84);
    serve(1, 0, 2, 32'h80FF_0000);
    chk("lbu_wb_wdata", wb_rf_wdata, 32'h0000_0080);

    // SH at 0x102, gnt in third REQ cycle
    issue(OP_SH, 32'h102, 32'h1234_ABCD, 0, 1'b0, 5'd0, 32'h88);
    serve(0, 2, 0, 0);
    chk("sh_req_cycles", req_cycles, 3);
    chk("sh_ready_low", rdy_seen, 0);
    chk("sh_be", o_be, 32'hC);
    chk("sh_wdata", o_wd, 32'hABCD_ABCD);
    chk("sh_addr", o_addr, 32'h100);
    chk("sh_wb_valid", 32'(wb_valid), 1);

    // Misaligned LW
    issue(OP_LW, 32'h101, 0, 0, 1'b1, 5'd5, 32'h40);
    chk("mis_exc", 32'(misalign_exc), 1);
    chk("mis_pc", exc_pc, 32'h40);
    chk("mis_req", 32'(dmem_req), 0);
    tick();
    chk("mis_wb_valid", 32'(wb_valid), 0);
    chk("mis_exc_pulse", 32'(misalign_exc), 0);

    // Flush during WAIT of LW
    issue(OP_LW, 32'h200, 0, 0, 1'b1, 5'd7, 32'h90);
    dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_fwd_we", 32'(fwd_we), 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    ex_valid = 1'b1; ex_mem_op = OP_NONE; ex_rf_we = 1'b1; ex_rf_waddr = 5'd4; ex_result = 32'h55;
    #1;
    chk("flush_ready_rvalid", 32'(ex_ready), 1);
    chk("flush_fwd_rvalid", 32'(fwd_we), 0);
    tick();
    dmem_rvalid = 1'b0; ex_valid = 1'b0;
    chk("flush_wb_valid", 32'(wb_valid), 0);
    tick();
    chk("flush_next_wb", 32'(wb_valid), 1);
    chk("flush_next_wdata", wb_rf_wdata, 32'h55);

    // Reset while in REQ
    issue(OP_LW, 32'h300, 0, 0, 1'b1, 5'd2, 32'hA0);
    chk("rstreq_req", 32'(dmem_req), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstreq_req_drop", 32'(dmem_req), 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstreq_wb_valid", 32'(wb_valid), 0);
    chk("rstreq_wdata", wb_rf_wdata, 0);
    chk("rstreq_fwd_we", 32'(fwd_we), 0);
    chk("rstreq_ready", 32'(ex_ready), 1);

    // Randomized single-transaction traffic
    for (int n = 0; n < 60; n++) begin
      op  = 4'($urandom_range(0, 8));
      a   = $urandom;
      wd  = $urandom;
      res = $urandom;
      pc  = $urandom;
      rd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      gl  = $urandom_range(0, 3);
      rl  = $urandom_range(0, 3);
      issue(op, a, wd, res, we, wa, pc);
      if (op == OP_NONE || ref_mis(op, a)) begin
        chk("rnd_exc", 32'(misalign_exc), 32'(ref_mis(op, a)));
        if (ref_mis(op, a)) chk("rnd_exc_pc", exc_pc, pc);
        chk("rnd_noreq", 32'(dmem_req), 0);
        tick();
        chk("rnd_wb_valid", 32'(wb_valid), 32'(!ref_mis(op, a)));
        exp = res;
      end else begin
        serve(op <= OP_LW, gl, rl, rd);
        chk("rnd_req_cycles", req_cycles, gl + 1);
        chk("rnd_ready_low", rdy_seen, 0);
        chk("rnd_addr", o_addr, a & 32'hFFFF_FFFC);
        chk("rnd_we", o_we, 32'(op >= OP_SB));
        if (op >= OP_SB) begin
          chk("rnd_be", o_be, ref_be(op, a));
          chk("rnd_sdata", o_wd, ref_sdata(op, wd));
          exp = res;
        end else begin
          exp = ref_load(op, a, rd);
          chk("rnd_busy", busy_low, 0);
          chk("rnd_fwd_we", o_fwd_we, 32'(we));
          if (we) chk("rnd_fwd", o_fwd, exp);
        end
        chk("rnd_wb_valid", 32'(wb_valid), 1);
      end
      if (wb_valid) begin
        chk("rnd_wb_pc", wb_pc, pc);
        chk("rnd_wb_we", 32'(wb_rf_we), 32'(we));
        chk("rnd_wb_waddr", 32'(wb_rf_waddr), 32'(wa));
        chk("rnd_wb_wdata", wb_rf_wdata, exp);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
